// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake feeding the UART transmitter FIFO.
// The producer side uses the master modport and the transmitter uses slave.
interface uart_tx_if;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiir;

    modport master (
        output axiiv,
        output axiid,
        input  axiir
    );

    modport slave (
        input  axiiv,
        input  axiid,
        output axiir
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered serial transmitter, 8N1 frames (start, 8 data LSB
// first, stop), back-to-back with no idle gap between queued bytes.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// (8E1 frames). Leave it undefined when pairing with the 8N1 uart_rx.
module uart_tx #(
    parameter int BAUD    = 'd9600,
    parameter int CLK_FRQ = 50_000_000,
    parameter int DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave byte_if,
    output logic     axiod,
    output logic     busy
);

    localparam int CYCLES_PER_BIT = CLK_FRQ / BAUD;
    localparam int PTR_W          = $clog2(DEPTH);
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   OCC_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   occ_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic last_cycle_s;

    // FIFO status, handshake and pop decision from registered state only.
    always_comb begin
        full_s       = (occ_r == OCC_FULL);
        empty_s      = (occ_r == OCC_ZERO);
        last_cycle_s = (cnt_r == CNT_LAST);
        // A full FIFO refuses the push even when a pop happens this cycle.
        push_s       = byte_if.axiiv && !full_s;
        pop_s        = 1'b0;
        if (!empty_s) begin
            if (state_r == IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == STOP) && last_cycle_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    assign byte_if.axiir = !full_s;

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            occ_r    <= OCC_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= byte_if.axiid;
        end
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            axiod   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        axiod   <= 1'b0;
                        busy    <= 1'b1;
                        cnt_r   <= CNT_ONE;
                        state_r <= START;
                    end else begin
                        axiod   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                START: begin
                    if (last_cycle_s) begin
                        idx_r   <= 3'd0;
                        cnt_r   <= CNT_ONE;
                        axiod   <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (last_cycle_s) begin
                        cnt_r <= CNT_ONE;
                        if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            axiod   <= even_parity(shift_r);
                            state_r <= PARITY;
`else
                            axiod   <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            axiod   <= shift_r[idx_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (last_cycle_s) begin
                        cnt_r   <= CNT_ONE;
                        axiod   <= 1'b1;
                        state_r <= STOP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (last_cycle_s) begin
                        if (pop_s) begin
                            // Next byte already queued: chain straight into its start bit.
                            shift_r <= mem_r[rd_ptr_r];
                            axiod   <= 1'b0;
                            cnt_r   <= CNT_ONE;
                            state_r <= START;
                        end else begin
                            axiod   <= 1'b1;
                            busy    <= 1'b0;
                            cnt_r   <= CNT_ZERO;
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    axiod   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
